// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with credit-limited requests, response FIFO and redirect
//
// Generates sequential word-aligned PCs, issues them to instruction memory
// over a valid/ready request channel, buffers in-order responses together
// with their PCs in a DEPTH-entry FIFO and presents the FIFO head to decode.
// A redirect flushes the FIFO, restarts fetch at a new PC and arranges for
// every response still in flight to be discarded when it returns.
//
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr      fetch request channel to instruction memory
//   imem_rsp_valid/data            in-order responses, no backpressure
//   inst_valid/ready, inst/inst_pc FIFO head to decode
//   redirect_valid/redirect_pc     flush and restart at redirect_pc & ~3
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop_cnt_nxt;
    logic [CW-1:0] fifo_count_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_stale;
    logic          pop;
    logic          credit_nxt;

    assign req_fire  = imem_req_valid && imem_req_ready;
    // A response landing in a redirect cycle belongs to the old stream.
    assign rsp_live  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign rsp_stale = imem_rsp_valid && (drop_cnt != '0);
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    assign imem_req_addr = fetch_pc;
    assign inst_valid    = (fifo_count != '0);
    assign inst          = fifo_inst[rd_ptr];
    assign inst_pc       = fifo_pc[rd_ptr];

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_nxt = outstanding + CW'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_nxt = outstanding - CW'(1);
        end

        fifo_count_nxt = fifo_count;
        if (redirect_valid) begin
            fifo_count_nxt = '0;
        end else if (rsp_live && !pop) begin
            fifo_count_nxt = fifo_count + CW'(1);
        end else if (!rsp_live && pop) begin
            fifo_count_nxt = fifo_count - CW'(1);
        end

        // After a redirect every request still in flight (including one
        // accepted this very cycle) is stale. A response retiring this cycle
        // is already removed from outstanding_nxt, whether it was live or
        // was itself a pending drop.
        drop_cnt_nxt = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_nxt = outstanding_nxt;
        end else if (rsp_stale) begin
            drop_cnt_nxt = drop_cnt - CW'(1);
        end

        // Registered request valid: look ahead at next-cycle occupancy so a
        // response can never arrive to a full FIFO.
        credit_nxt = ({1'b0, fifo_count_nxt} + {1'b0, outstanding_nxt}) < CREDITS;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req_valid <= 1'b0;
            fetch_pc       <= RESET_PC;
            rsp_pc         <= RESET_PC;
            outstanding    <= '0;
            drop_cnt       <= '0;
            fifo_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            imem_req_valid <= credit_nxt;
            outstanding    <= outstanding_nxt;
            drop_cnt       <= drop_cnt_nxt;
            fifo_count     <= fifo_count_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'd3;
                rsp_pc   <= redirect_pc & ~32'd3;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_live) begin
                    fifo_inst[wr_ptr] <= imem_rsp_data;
                    fifo_pc[wr_ptr]   <= rsp_pc;
                    rsp_pc            <= rsp_pc + 32'd4;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] MASK     = 32'hFFFF_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: fixed latency, in order, data = addr ^ MASK.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] acc_log[$];
    int          lat = 1;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          inflight = 0;
    int          stale_cnt = 0;
    logic        last_fire = 1'b0;
    logic        last_rsp = 1'b0;

    initial begin : mem_model
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            last_fire = imem_req_valid && imem_req_ready;
            last_rsp  = imem_rsp_valid;
            if (reset) begin
                acc_cnt   = 0;
                inflight  = 0;
                stale_cnt = 0;
                acc_log.delete();
                mq.delete();
            end else begin
                if (imem_rsp_valid) begin
                    inflight--;
                    if ((imem_rsp_data ^ MASK) < 32'h100) stale_cnt++;
                end
                if (last_fire) begin
                    mq.push_back('{imem_req_addr, cyc + lat});
                    acc_log.push_back(imem_req_addr);
                    acc_cnt++;
                    inflight++;
                end
            end
            #1;
            if (!reset && mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq[0].addr ^ MASK;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Decode-side scoreboard: every consumed instruction must be the next PC.
    logic [31:0] exp_pc = RESET_PC;
    int          pops = 0;

    initial begin : dec_mon
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_pc = RESET_PC;
            end else if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'd3;
            end else if (inst_valid && inst_ready) begin
                chk("dec_pc", inst_pc, exp_pc);
                chk("dec_inst", inst, exp_pc ^ MASK);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
    end

    typedef struct {
        logic        ir;
        logic        rr;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[13];

    task automatic do_reset(input int l);
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = l;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int p0;
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Streaming with 1-cycle memory, then decode stalls for three cycles.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        lat   = 1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            inst_ready     = vecs[i].ir;
            imem_req_ready = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].rv);
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].addr);
            chk($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].iv);
            if (vecs[i].iv) chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].pc);
        end

        // Decode blocked from reset: credits cap issue at DEPTH requests.
        do_reset(1);
        inst_ready = 1'b0;
        repeat (12) @(negedge clk);
        chk("s2_accepts", acc_cnt, 4);
        chk("s2_first_addr", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("s2_last_addr", acc_log.size() > 3 ? acc_log[3] : 32'hDEAD_BEEF, 32'hC);
        chk("s2_req_valid", imem_req_valid, 1'b0);
        chk("s2_inst_valid", inst_valid, 1'b1);
        chk("s2_inst_pc", inst_pc, 32'h0);
        chk("s2_inst", inst, 32'hFFFF_0000);
        inst_ready = 1'b1;
        n = 0;
        while (acc_cnt < 5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s2_resume_addr", acc_log.size() > 4 ? acc_log[4] : 32'hDEAD_BEEF, 32'h10);

        // Memory stalls the request to 0x8 for three cycles.
        do_reset(1);
        n = 0;
        while (!(imem_req_valid && imem_req_addr == 32'h8) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s3_reach_0x8", 32'(n < 20), 32'd1);
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("s3_hold%0d_valid", k), imem_req_valid, 1'b1);
            chk($sformatf("s3_hold%0d_addr", k), imem_req_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("s3_acc2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);
        chk("s3_acc3", acc_log.size() > 3 ? acc_log[3] : 32'hDEAD_BEEF, 32'hC);
        chk("s3_progress", 32'(exp_pc >= 32'h18), 32'd1);

        // 3-cycle memory, redirect with three requests in flight.
        do_reset(3);
        n = 0;
        while (inflight != 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s4_inflight3", 32'(inflight), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        imem_req_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("s4_flush_inst_valid", inst_valid, 1'b0);
        chk("s4_req_valid", imem_req_valid, 1'b1);
        chk("s4_req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        p0 = pops;
        repeat (12) @(negedge clk);
        chk("s4_stale_dropped", 32'(stale_cnt), 32'd3);
        chk("s4_delivered", 32'(pops > p0), 32'd1);

        // Redirect coinciding with a response and a request accept.
        do_reset(1);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("s5_setup_fire", last_fire, 1'b1);
        chk("s5_setup_rsp", last_rsp, 1'b1);
        chk("s5_req_addr", imem_req_addr, 32'h200);
        chk("s5_req_valid", imem_req_valid, 1'b1);
        chk("s5_inst_valid0", inst_valid, 1'b0);
        @(negedge clk);
        chk("s5_stale_inst_valid", inst_valid, 1'b0);
        chk("s5_req_addr2", imem_req_addr, 32'h204);
        @(negedge clk);
        chk("s5_inst_valid", inst_valid, 1'b1);
        chk("s5_inst_pc", inst_pc, 32'h200);
        chk("s5_inst", inst, 32'h200 ^ MASK);

        // Asynchronous reset between clock edges mid-stream.
        do_reset(1);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_req_valid", imem_req_valid, 1'b0);
        chk("s6_async_inst_valid", inst_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("s6_restart_valid", imem_req_valid, 1'b1);
        chk("s6_restart_addr", imem_req_addr, RESET_PC);
        p0 = pops;
        repeat (6) @(negedge clk);
        chk("s6_delivered", 32'(pops > p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
